// File: rtl/l2_tcdm_responder.sv
// ---------------------------------------------------------------------------
// l2_tcdm_responder
//
// Target-side endpoint of the 36-bit L2 TCDM protocol. Requests from an
// initiator (req/gnt handshake) are serviced from one single-port SRAM bank
// whose words hold {tag[3:0], data[31:0]}. Every granted request produces
// exactly one r_valid beat MEM_LATENCY cycles after its grant, in order.
// Out-of-range accesses never touch the SRAM and are answered with r_opc = 1.
// Saturating read/write/error event counters track issued responses.
//
// Configuration macro:
//   TCDM_RESP_ALIGN_CHECK_EN - when defined, a granted request whose byte
//                              address is not word aligned is answered as an
//                              error. When undefined, add_i[1:0] is ignored.
//
// Parameters:
//   ADDR_WIDTH  - word-address width of the SRAM bank
//   BASE_ADDR   - byte base address of the bank
//   MEM_LATENCY - SRAM read latency in cycles (1 or 2)
//   CNT_WIDTH   - width of each event counter (>= 2)
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i, add_i, wen_i,     request valid, byte address, 1 = read,
//   wdata_i, be_i            write data {tag, data}, byte enables
//   gnt_o                    request accepted this cycle (combinational)
//   r_valid_o, r_rdata_o,    response beat, read data, error flag
//   r_opc_o
//   mem_req_o, mem_we_o,     SRAM command (combinational, zero when idle)
//   mem_addr_o, mem_wdata_o,
//   mem_bwe_o
//   mem_rdata_i              SRAM read data, MEM_LATENCY cycles after access
//   mem_stall_i              SRAM busy, no access allowed
//   cnt_clr_i                synchronous clear of all counters
//   rd_cnt_o, wr_cnt_o,      saturating event counters
//   err_cnt_o
// ---------------------------------------------------------------------------
module l2_tcdm_responder #(
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h1C00_0000,
    parameter int          MEM_LATENCY = 1,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_i,
    input  logic [31:0]           add_i,
    input  logic                  wen_i,
    input  logic [35:0]           wdata_i,
    input  logic [3:0]            be_i,
    output logic                  gnt_o,
    output logic                  r_valid_o,
    output logic [35:0]           r_rdata_o,
    output logic                  r_opc_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [35:0]           mem_wdata_o,
    output logic [35:0]           mem_bwe_o,
    input  logic [35:0]           mem_rdata_i,
    input  logic                  mem_stall_i,
    input  logic                  cnt_clr_i,
    output logic [CNT_WIDTH-1:0]  rd_cnt_o,
    output logic [CNT_WIDTH-1:0]  wr_cnt_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o
);

    // Size of the bank in bytes; a full 33-bit value so the range compare
    // uses every bit of the 32-bit offset without overflow.
    localparam logic [32:0] RANGE_SPAN = 33'd1 << (ADDR_WIDTH + 2);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // One entry of the response pipeline.
    typedef struct packed {
        logic valid;
        logic is_read;
        logic is_err;
    } resp_t;

    localparam resp_t RESP_IDLE = 3'b000;

    // Expand the 4 byte enables into the 36-bit SRAM bit mask:
    // be[i] covers data byte i and tag bit i.
    function automatic logic [35:0] expand_be(input logic [3:0] be);
        logic [35:0] mask;
        mask = 36'd0;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
            mask[32+i]     = be[i];
        end
        return mask;
    endfunction

    // Saturating increment: holds at all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] value,
        input logic                 enable
    );
        logic [CNT_WIDTH-1:0] result;
        if (enable && (value != CNT_MAX)) begin
            result = value + CNT_ONE;
        end else begin
            result = value;
        end
        return result;
    endfunction

    logic [31:0]          offset_s;
    logic                 in_range_s;
    logic                 misaligned_s;
    logic                 gnt_s;
    logic                 is_err_s;
    logic                 access_s;
    resp_t                stage_in_s;
    resp_t                resp_out_s;
    logic                 good_rd_s;
    logic                 good_wr_s;
    logic                 bad_s;

    resp_t                pipe_r [MEM_LATENCY];
    logic [CNT_WIDTH-1:0] rd_cnt_r;
    logic [CNT_WIDTH-1:0] wr_cnt_r;
    logic [CNT_WIDTH-1:0] err_cnt_r;

    // Request decode: bank offset, range/alignment classification and grant.
    always_comb begin
        offset_s   = add_i - BASE_ADDR;
        // Unsigned compare: addresses below the base wrap to huge offsets.
        in_range_s = ({1'b0, offset_s} < RANGE_SPAN);
`ifdef TCDM_RESP_ALIGN_CHECK_EN
        misaligned_s = (add_i[1:0] != 2'b00);
`else
        misaligned_s = 1'b0;
`endif
        // No response backpressure exists, so only the SRAM stall gates grant.
        gnt_s    = req_i & ~mem_stall_i;
        is_err_s = ~in_range_s | misaligned_s;
        access_s = gnt_s & ~is_err_s;
    end

    // SRAM command: driven only for granted, error-free requests.
    always_comb begin
        gnt_o       = gnt_s;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {ADDR_WIDTH{1'b0}};
        mem_wdata_o = 36'd0;
        mem_bwe_o   = 36'd0;
        if (access_s) begin
            mem_req_o   = 1'b1;
            mem_we_o    = ~wen_i;
            mem_addr_o  = offset_s[ADDR_WIDTH+1:2];
            mem_wdata_o = wdata_i;
            mem_bwe_o   = expand_be(be_i);
        end else begin
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_addr_o  = {ADDR_WIDTH{1'b0}};
            mem_wdata_o = 36'd0;
            mem_bwe_o   = 36'd0;
        end
    end

    // Pipeline input: one entry per granted request, errors included, so
    // error beats keep the same latency and responses stay in order.
    always_comb begin
        stage_in_s = RESP_IDLE;
        if (gnt_s) begin
            stage_in_s.valid   = 1'b1;
            stage_in_s.is_read = wen_i;
            stage_in_s.is_err  = is_err_s;
        end else begin
            stage_in_s = RESP_IDLE;
        end
    end

    // Response shift register, MEM_LATENCY deep, aligned with the SRAM read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe_r[i] <= RESP_IDLE;
            end
        end else begin
            pipe_r[0] <= stage_in_s;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Response outputs: the SRAM data is only forwarded for good reads.
    always_comb begin
        resp_out_s = pipe_r[MEM_LATENCY-1];
        r_valid_o  = resp_out_s.valid;
        r_opc_o    = resp_out_s.is_err;
        if (resp_out_s.is_read && !resp_out_s.is_err) begin
            r_rdata_o = mem_rdata_i;
        end else begin
            r_rdata_o = 36'd0;
        end
        good_rd_s = resp_out_s.valid &  resp_out_s.is_read & ~resp_out_s.is_err;
        good_wr_s = resp_out_s.valid & ~resp_out_s.is_read & ~resp_out_s.is_err;
        bad_s     = resp_out_s.valid &  resp_out_s.is_err;
    end

    // Event counters: count issued beats; a clear wins over an increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_r  <= {CNT_WIDTH{1'b0}};
            wr_cnt_r  <= {CNT_WIDTH{1'b0}};
            err_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (cnt_clr_i) begin
            rd_cnt_r  <= {CNT_WIDTH{1'b0}};
            wr_cnt_r  <= {CNT_WIDTH{1'b0}};
            err_cnt_r <= {CNT_WIDTH{1'b0}};
        end else begin
            rd_cnt_r  <= sat_inc(rd_cnt_r, good_rd_s);
            wr_cnt_r  <= sat_inc(wr_cnt_r, good_wr_s);
            err_cnt_r <= sat_inc(err_cnt_r, bad_s);
        end
    end

    assign rd_cnt_o  = rd_cnt_r;
    assign wr_cnt_o  = wr_cnt_r;
    assign err_cnt_o = err_cnt_r;

endmodule

// File: tb/tb_l2_tcdm_responder.sv
// Testbench for l2_tcdm_responder. Two instances share one stimulus stream:
// instance A uses MEM_LATENCY = 1 with 16-bit counters, instance B uses
// MEM_LATENCY = 2 with 3-bit counters so saturation is reachable quickly.
// Each instance has its own behavioural SRAM; expected beats and counter
// values come from a transaction-level model (reference memory array plus
// per-instance queues of due responses).
module tb_l2_tcdm_responder;

    localparam logic [31:0] BASE = 32'h1C00_0000;
    localparam int CMAX_A = 65535;
    localparam int CMAX_B = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni, req, wen, stall, clr, mem_init;
    logic [31:0] add;
    logic [35:0] wdata;
    logic [3:0]  be;

    logic        gnt_a, r_valid_a, r_opc_a, mem_req_a, mem_we_a;
    logic [35:0] r_rdata_a, mem_wdata_a, mem_bwe_a, mem_rdata_a;
    logic [11:0] mem_addr_a;
    logic [15:0] rd_cnt_a, wr_cnt_a, err_cnt_a;

    logic        gnt_b, r_valid_b, r_opc_b, mem_req_b, mem_we_b;
    logic [35:0] r_rdata_b, mem_wdata_b, mem_bwe_b, mem_rdata_b, rdata_b_q;
    logic [11:0] mem_addr_b;
    logic [2:0]  rd_cnt_b, wr_cnt_b, err_cnt_b;

    l2_tcdm_responder #(.ADDR_WIDTH(12), .BASE_ADDR(BASE), .MEM_LATENCY(1), .CNT_WIDTH(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt_a), .r_valid_o(r_valid_a),
        .r_rdata_o(r_rdata_a), .r_opc_o(r_opc_a), .mem_req_o(mem_req_a),
        .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a), .mem_wdata_o(mem_wdata_a),
        .mem_bwe_o(mem_bwe_a), .mem_rdata_i(mem_rdata_a), .mem_stall_i(stall),
        .cnt_clr_i(clr), .rd_cnt_o(rd_cnt_a), .wr_cnt_o(wr_cnt_a), .err_cnt_o(err_cnt_a)
    );

    l2_tcdm_responder #(.ADDR_WIDTH(12), .BASE_ADDR(BASE), .MEM_LATENCY(2), .CNT_WIDTH(3)) dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt_b), .r_valid_o(r_valid_b),
        .r_rdata_o(r_rdata_b), .r_opc_o(r_opc_b), .mem_req_o(mem_req_b),
        .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b),
        .mem_bwe_o(mem_bwe_b), .mem_rdata_i(mem_rdata_b), .mem_stall_i(stall),
        .cnt_clr_i(clr), .rd_cnt_o(rd_cnt_b), .wr_cnt_o(wr_cnt_b), .err_cnt_o(err_cnt_b)
    );

    // Behavioural SRAM cuts: latency 1 for A, latency 2 for B.
    logic [35:0] sram_a [4096];
    logic [35:0] sram_b [4096];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) sram_a[i] <= 36'd0;
            mem_rdata_a <= 36'd0;
        end else if (mem_req_a) begin
            if (mem_we_a) sram_a[mem_addr_a] <= (sram_a[mem_addr_a] & ~mem_bwe_a) | (mem_wdata_a & mem_bwe_a);
            else          mem_rdata_a <= sram_a[mem_addr_a];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) sram_b[i] <= 36'd0;
            rdata_b_q <= 36'd0;
        end else if (mem_req_b) begin
            if (mem_we_b) sram_b[mem_addr_b] <= (sram_b[mem_addr_b] & ~mem_bwe_b) | (mem_wdata_b & mem_bwe_b);
            else          rdata_b_q <= sram_b[mem_addr_b];
        end
        mem_rdata_b <= rdata_b_q;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [37:0] beat;   // {valid, opc, rdata}
        int          kind;   // 0 read, 1 write, 2 error
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [35:0] ref_mem [4096];
    logic [37:0] exp_beat [2];
    int          pend [2];
    int          cnt_m [2][3];
    int          edge_n = 0;
    int          checks = 0;
    int          passed = 0;

    function automatic void model_clear();
        q_a.delete();
        q_b.delete();
        for (int d = 0; d < 2; d++) begin
            exp_beat[d] = 38'd0;
            pend[d] = -1;
            for (int k = 0; k < 3; k++) cnt_m[d][k] = 0;
        end
    endfunction

    function automatic logic [75:0] got_resp();
        return {r_valid_a, r_opc_a, r_rdata_a, r_valid_b, r_opc_b, r_rdata_b};
    endfunction

    function automatic logic [75:0] exp_resp();
        return {exp_beat[0], exp_beat[1]};
    endfunction

    function automatic logic [56:0] got_cnt();
        return {rd_cnt_a, wr_cnt_a, err_cnt_a, rd_cnt_b, wr_cnt_b, err_cnt_b};
    endfunction

    function automatic logic [56:0] exp_cnt();
        return {16'(cnt_m[0][0]), 16'(cnt_m[0][1]), 16'(cnt_m[0][2]),
                3'(cnt_m[1][0]), 3'(cnt_m[1][1]), 3'(cnt_m[1][2])};
    endfunction

    // Error rule straight from the address map.
    function automatic logic addr_err(input logic [31:0] a);
        logic [31:0] off;
        logic        e;
        off = a - BASE;
        e = (off >= 32'h0000_4000);
`ifdef TCDM_RESP_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) e = 1'b1;
`endif
        return e;
    endfunction

    // Advance one clock: record the transaction granted in this cycle, then
    // update counters at the edge and expected beats at the following negedge.
    task automatic tick();
        logic [31:0] off;
        logic        err;
        logic [11:0] w;
        logic [35:0] d;
        int          kind;
        if (req && !stall) begin
            off = add - BASE;
            err = addr_err(add);
            w = off[13:2];
            d = 36'd0;
            if (err) kind = 2;
            else if (wen) begin
                kind = 0;
                d = ref_mem[w];
            end else begin
                kind = 1;
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        ref_mem[w][8*i +: 8] = wdata[8*i +: 8];
                        ref_mem[w][32+i]     = wdata[32+i];
                    end
                end
            end
            q_a.push_back('{due: edge_n + 1, beat: {1'b1, err, d}, kind: kind});
            q_b.push_back('{due: edge_n + 2, beat: {1'b1, err, d}, kind: kind});
        end
        @(posedge clk);
        edge_n++;
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                for (int j = 0; j < 3; j++) cnt_m[k][j] = 0;
            end else if (pend[k] >= 0) begin
                if (cnt_m[k][pend[k]] < ((k == 0) ? CMAX_A : CMAX_B)) cnt_m[k][pend[k]]++;
            end
        end
        @(negedge clk);
        exp_beat[0] = 38'd0; pend[0] = -1;
        exp_beat[1] = 38'd0; pend[1] = -1;
        if (q_a.size() > 0 && q_a[0].due == edge_n) begin
            exp_beat[0] = q_a[0].beat; pend[0] = q_a[0].kind; void'(q_a.pop_front());
        end
        if (q_b.size() > 0 && q_b[0].due == edge_n) begin
            exp_beat[1] = q_b[0].beat; pend[1] = q_b[0].kind; void'(q_b.pop_front());
        end
    endtask

    task automatic set_req(input logic [31:0] a, input logic rd, input logic [35:0] wd, input logic [3:0] b);
        req = 1'b1; add = a; wen = rd; wdata = wd; be = b;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_ni = 1'b0; req = 1'b0; add = 32'd0; wen = 1'b0; wdata = 36'd0;
        be = 4'd0; stall = 1'b0; clr = 1'b0; mem_init = 1'b1;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 36'd0;
        model_clear();
        tick();
        mem_init = 1'b0;
        tick();
        checks++;
        if (got_resp() !== 76'd0) $display("FAIL reset_resp got=%h expected=0", got_resp());
        else passed++;
        checks++;
        if (got_cnt() !== 57'd0) $display("FAIL reset_cnt got=%h expected=0", got_cnt());
        else passed++;
        checks++;
        if ({gnt_a, mem_req_a, mem_we_a, mem_addr_a, mem_wdata_a, mem_bwe_a,
             gnt_b, mem_req_b, mem_we_b, mem_addr_b, mem_wdata_b, mem_bwe_b} !== 174'd0)
            $display("FAIL reset_mem_if gnt_a=%b mem_req_a=%b gnt_b=%b mem_req_b=%b expected all zero",
                     gnt_a, mem_req_a, gnt_b, mem_req_b);
        else passed++;
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        set_req(32'h1C00_0010, 1'b0, 36'hA_DEADBEEF, 4'hF);
        #1;
        checks++;
        if ({gnt_a, mem_req_a, mem_we_a, mem_addr_a, mem_bwe_a} !== {1'b1, 1'b1, 1'b1, 12'h004, 36'hF_FFFF_FFFF})
            $display("FAIL wr_cmd got gnt=%b req=%b we=%b addr=%h bwe=%h expected 1 1 1 004 fffffffff",
                     gnt_a, mem_req_a, mem_we_a, mem_addr_a, mem_bwe_a);
        else passed++;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) set_req(32'h1C00_0010, 1'b1, 36'd0, 4'hF);
            else if (c >= 2) req = 1'b0;
            tick();
            checks++;
            if (got_resp() !== exp_resp()) $display("FAIL wr_rd_resp c=%0d got=%h expected=%h", c, got_resp(), exp_resp());
            else passed++;
            checks++;
            if (got_cnt() !== exp_cnt()) $display("FAIL wr_rd_cnt c=%0d got=%h expected=%h", c, got_cnt(), exp_cnt());
            else passed++;
            if (c == 1) begin
                checks++;
                if ({r_valid_a, r_rdata_a} !== {1'b1, 36'hA_DEADBEEF})
                    $display("FAIL wr_rd_data got v=%b d=%h expected 1 adeadbeef", r_valid_a, r_rdata_a);
                else passed++;
            end
        end
        checks++;
        if ({rd_cnt_a, wr_cnt_a} !== {16'd1, 16'd1})
            $display("FAIL wr_rd_counts got rd=%0d wr=%0d expected 1 1", rd_cnt_a, wr_cnt_a);
        else passed++;
    endtask

    task automatic test_partial_write();
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: set_req(32'h1C00_0020, 1'b0, 36'd0, 4'hF);
                1: set_req(32'h1C00_0020, 1'b0, 36'hF_FFFF_FFFF, 4'b0101);
                2: set_req(32'h1C00_0020, 1'b1, 36'd0, 4'hF);
                default: req = 1'b0;
            endcase
            tick();
            checks++;
            if (got_resp() !== exp_resp()) $display("FAIL partial_resp c=%0d got=%h expected=%h", c, got_resp(), exp_resp());
            else passed++;
            if (c == 2) begin
                checks++;
                if ({r_valid_a, r_rdata_a} !== {1'b1, 36'h5_00FF_00FF})
                    $display("FAIL partial_data got v=%b d=%h expected 1 500ff00ff", r_valid_a, r_rdata_a);
                else passed++;
            end
        end
    endtask

    task automatic test_out_of_range();
        req = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        set_req(32'h1C00_4000, 1'b1, 36'd0, 4'hF);
        #1;
        checks++;
        if ({gnt_a, mem_req_a, gnt_b, mem_req_b} !== 4'b1010)
            $display("FAIL oor_cmd got gnt_a=%b req_a=%b gnt_b=%b req_b=%b expected 1 0 1 0", gnt_a, mem_req_a, gnt_b, mem_req_b);
        else passed++;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) req = 1'b0;
            tick();
            checks++;
            if (got_resp() !== exp_resp()) $display("FAIL oor_resp c=%0d got=%h expected=%h", c, got_resp(), exp_resp());
            else passed++;
            if (c == 0) begin
                checks++;
                if ({r_valid_a, r_opc_a, r_rdata_a} !== {1'b1, 1'b1, 36'd0})
                    $display("FAIL oor_beat got v=%b opc=%b d=%h expected 1 1 0", r_valid_a, r_opc_a, r_rdata_a);
                else passed++;
            end
        end
        checks++;
        if ({err_cnt_a, err_cnt_b, rd_cnt_a} !== {16'd1, 3'd1, 16'd0})
            $display("FAIL oor_cnt got err_a=%0d err_b=%0d rd_a=%0d expected 1 1 0", err_cnt_a, err_cnt_b, rd_cnt_a);
        else passed++;
    endtask

    task automatic test_stall_latency();
        logic [31:0] addrs [4];
        int idx = 0;
        int beats_b = 0;
        logic g;
        addrs = '{32'h1C00_0010, 32'h1C00_0020, 32'h1C00_0014, 32'h1C00_0000};
        for (int c = 0; c < 10; c++) begin
            stall = (c >= 2 && c <= 4);
            if (idx < 4) set_req(addrs[idx], 1'b1, 36'd0, 4'hF);
            else req = 1'b0;
            #1;
            g = req && !stall;
            checks++;
            if ({gnt_a, gnt_b} !== {g, g}) $display("FAIL stall_gnt c=%0d got a=%b b=%b expected %b", c, gnt_a, gnt_b, g);
            else passed++;
            if (g) idx++;
            tick();
            checks++;
            if (got_resp() !== exp_resp()) $display("FAIL stall_resp c=%0d got=%h expected=%h", c, got_resp(), exp_resp());
            else passed++;
            if (r_valid_b) beats_b++;
        end
        stall = 1'b0;
        checks++;
        if (beats_b != 4) $display("FAIL stall_beats got=%0d expected=4", beats_b);
        else passed++;
    endtask

    task automatic test_alignment();
        logic [37:0] exp_a;
`ifdef TCDM_RESP_ALIGN_CHECK_EN
        exp_a = {1'b1, 1'b1, 36'd0};
`else
        exp_a = {1'b1, 1'b0, 36'h3_1234_5678};
`endif
        for (int c = 0; c < 5; c++) begin
            if (c == 0) set_req(32'h1C00_0000, 1'b0, 36'h3_1234_5678, 4'hF);
            else if (c == 1) set_req(32'h1C00_0002, 1'b1, 36'd0, 4'hF);
            else req = 1'b0;
            tick();
            checks++;
            if (got_resp() !== exp_resp()) $display("FAIL align_resp c=%0d got=%h expected=%h", c, got_resp(), exp_resp());
            else passed++;
            if (c == 1) begin
                checks++;
                if ({r_valid_a, r_opc_a, r_rdata_a} !== exp_a)
                    $display("FAIL align_beat got=%h expected=%h", {r_valid_a, r_opc_a, r_rdata_a}, exp_a);
                else passed++;
            end
        end
    endtask

    task automatic test_saturation_clear();
        req = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c < 9) set_req(32'h1C00_0010, 1'b1, 36'd0, 4'hF);
            else req = 1'b0;
            tick();
            checks++;
            if (got_cnt() !== exp_cnt()) $display("FAIL sat_cnt c=%0d got=%h expected=%h", c, got_cnt(), exp_cnt());
            else passed++;
        end
        checks++;
        if ({rd_cnt_a, rd_cnt_b} !== {16'd9, 3'd7}) $display("FAIL sat_value got rd_a=%0d rd_b=%0d expected 9 7", rd_cnt_a, rd_cnt_b);
        else passed++;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) set_req(32'h1C00_0010, 1'b1, 36'd0, 4'hF);
            else req = 1'b0;
            clr = (c == 1);
            tick();
            checks++;
            if (got_cnt() !== exp_cnt()) $display("FAIL clr_cnt c=%0d got=%h expected=%h", c, got_cnt(), exp_cnt());
            else passed++;
        end
        clr = 1'b0;
        checks++;
        if ({rd_cnt_a, rd_cnt_b} !== {16'd0, 3'd1}) $display("FAIL clr_priority got rd_a=%0d rd_b=%0d expected 0 1", rd_cnt_a, rd_cnt_b);
        else passed++;
    endtask

    task automatic test_random();
        logic [31:0] off;
        logic        g, mr;
        logic [35:0] bwe;
        for (int c = 0; c < 400; c++) begin
            if (!(req && stall)) begin
                req = ($urandom_range(0, 4) != 0);
                case ($urandom_range(0, 7))
                    0: add = $urandom;
                    1: add = BASE + 32'h0000_4000 + 32'($urandom_range(0, 255));
                    2: add = BASE - 32'd4;
                    3: add = BASE + 32'h0000_3FFC;
                    default: add = BASE + 32'($urandom_range(0, 255));
                endcase
                wen = $urandom_range(0, 1) == 1;
                wdata = {4'($urandom_range(0, 15)), $urandom};
                be = 4'($urandom_range(0, 15));
            end
            stall = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 19) == 0);
            #1;
            off = add - BASE;
            g = req && !stall;
            mr = g && !addr_err(add);
            checks++;
            if ({gnt_a, mem_req_a, gnt_b, mem_req_b} !== {g, mr, g, mr})
                $display("FAIL rnd_cmd c=%0d got %b%b%b%b expected %b%b%b%b", c, gnt_a, mem_req_a, gnt_b, mem_req_b, g, mr, g, mr);
            else passed++;
            if (mr) begin
                for (int i = 0; i < 4; i++) begin
                    bwe[8*i +: 8] = {8{be[i]}};
                    bwe[32+i] = be[i];
                end
                checks++;
                if ({mem_we_a, mem_addr_a, mem_wdata_a, mem_bwe_a} !== {~wen, off[13:2], wdata, bwe})
                    $display("FAIL rnd_mem c=%0d got we=%b addr=%h wd=%h bwe=%h expected we=%b addr=%h wd=%h bwe=%h",
                             c, mem_we_a, mem_addr_a, mem_wdata_a, mem_bwe_a, ~wen, off[13:2], wdata, bwe);
                else passed++;
            end
            tick();
            checks++;
            if (got_resp() !== exp_resp()) $display("FAIL rnd_resp c=%0d got=%h expected=%h", c, got_resp(), exp_resp());
            else passed++;
            checks++;
            if (got_cnt() !== exp_cnt()) $display("FAIL rnd_cnt c=%0d got=%h expected=%h", c, got_cnt(), exp_cnt());
            else passed++;
        end
        req = 1'b0; stall = 1'b0; clr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (got_resp() !== exp_resp()) $display("FAIL rnd_drain c=%0d got=%h expected=%h", c, got_resp(), exp_resp());
            else passed++;
        end
    endtask

    task automatic test_reset_in_flight();
        set_req(32'h1C00_0010, 1'b1, 36'd0, 4'hF);
        tick();
        checks++;
        if (got_resp() !== exp_resp()) $display("FAIL rif_pre got=%h expected=%h", got_resp(), exp_resp());
        else passed++;
        req = 1'b0;
        rst_ni = 1'b0;
        model_clear();
        #1;
        checks++;
        if ({r_valid_a, r_valid_b} !== 2'b00) $display("FAIL rif_async got va=%b vb=%b expected 0 0", r_valid_a, r_valid_b);
        else passed++;
        tick();
        tick();
        rst_ni = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (got_resp() !== exp_resp()) $display("FAIL rif_resp c=%0d got=%h expected=%h", c, got_resp(), exp_resp());
            else passed++;
        end
        checks++;
        if (got_cnt() !== 57'd0) $display("FAIL rif_cnt got=%h expected=0", got_cnt());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_write();
        test_out_of_range();
        test_stall_latency();
        test_alignment();
        test_saturation_clear();
        test_random();
        test_reset_in_flight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
